fk_delay_seq: RTL and testbench
===============================

FK_DELAY_SEQ -- requirements
Module: fk_delay_seq

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: single system clock; all state updates on its rising edge.
REQ-002 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 The block SHALL have port start, input, 1 bit: new-sample strobe, sampled on the rising edge of clk.
REQ-004 The block SHALL have port x_in, input, 25 bits: new signed sample, captured when start is accepted.
REQ-005 The block SHALL have port clr_ovr, input, 1 bit: clears the overrun flag.
REQ-006 The block SHALL have ports fk, fk_1 and fk_2, output, 25 bits each: current, one-back and two-back samples, all registered.
REQ-007 The block SHALL have port select, output, 2 bits: registered tap select for the downstream 4:1 sample mux (00 = zero, 01 = fk, 10 = fk_1, 11 = fk_2).
REQ-008 The block SHALL have port mac_first, output, 1 bit: high on the first tap cycle so the downstream accumulator loads rather than adds.
REQ-009 The block SHALL have port busy, output, 1 bit: high while a tap sequence is in progress.
REQ-010 The block SHALL have port done, output, 1 bit: one-cycle pulse when the tap sequence is complete.
REQ-011 The block SHALL have port overrun, output, 1 bit: sticky flag set by a start that is rejected.

Function
REQ-012 FSM states SHALL be exactly IDLE, TAP0, TAP1, TAP2 and FIN, with state, select, mac_first, busy and done all registered.
REQ-013 IDLE transitions SHALL be: start=1 -> TAP0, with fk<=x_in, fk_1<=fk and fk_2<=fk_1 on the same edge; start=0 -> remain in IDLE, delay line held.
REQ-014 State sequencing SHALL be TAP0 -> TAP1 -> TAP2 -> FIN -> IDLE, one clock per state, unconditionally.
REQ-015 Output decode SHALL be:
- IDLE: select=00, busy=0.
- TAP0: select=01, mac_first=1, busy=1.
- TAP1: select=10, busy=1.
- TAP2: select=11, busy=1.
- FIN: select=00, done=1, busy=1.
- Any output not listed for a state SHALL be 0 in that state.
REQ-016 Latency SHALL be: the edge accepting start is edge 0; select=01 is visible after edge 0; done=1 is visible after edge 3.
REQ-017 Maximum throughput SHALL be one sample per 5 clocks (back-to-back start accepted when asserted in IDLE).
REQ-018 The delay line SHALL shift only on an accepted start; fk, fk_1 and fk_2 SHALL be stable throughout TAP0..FIN.
REQ-019 Delay-line values SHALL be copied bit-exact, with no sign extension, truncation or arithmetic.
REQ-020 Rejected start: start=1 in any state other than IDLE SHALL be ignored (no shift, no restart) and SHALL set overrun=1.
REQ-021 Overrun clear: clr_ovr=1 SHALL clear overrun on the next edge; if clr_ovr=1 and a rejected start occur on the same edge, overrun SHALL be 1 (set wins).
REQ-022 Start is level-sampled: start held high SHALL be accepted again on each return to IDLE, and SHALL flag overrun for each non-IDLE cycle in which it is high.
REQ-023 Illegal or unreachable state encodings SHALL return to IDLE on the next edge, with outputs as for IDLE.

Reset
REQ-024 reset=1 at a rising edge SHALL force state=IDLE, fk=fk_1=fk_2=0, select=00, mac_first=0, busy=0, done=0 and overrun=0, regardless of other inputs, including mid-sequence.
REQ-025 Reset SHALL take priority over start and clr_ovr on the same edge; start asserted with reset SHALL be discarded.
REQ-026 The first edge with reset=0 SHALL behave as IDLE.

Verification
REQ-027 Reset then single sample: x_in=25'h0000123 with start for 1 clk -> fk=123, fk_1=0, fk_2=0; select 01,10,11,00 on consecutive cycles; mac_first=1 only with select=01; done=1 exactly 4 cycles after start.
REQ-028 Three samples A=1, B=2, C=3, each started in IDLE -> after C: fk=3, fk_1=2, fk_2=1; each sequence produces exactly one done pulse.
REQ-029 Overrun: start pulses in IDLE and again in TAP1 with x_in=25'h1FFFFFF -> delay line unchanged by the second pulse, sequence completes normally, overrun=1 and held; clr_ovr for 1 clk -> overrun=0.
REQ-030 Reset mid-sequence: assert reset in TAP2 -> next cycle all outputs 0 and IDLE; a following start runs a clean sequence with fk_1=0.
REQ-031 Continuous start held high for 20 clks -> accepted every 5 clocks (4 accepts), overrun=1, delay line shifts 4 times.
REQ-032 Boundary data: x_in=25'h1000000 then 25'h0FFFFFF -> fk_1=25'h1000000 and fk=25'h0FFFFFF, bit-exact.

Source files
------------

// File: rtl/fk_delay_seq.sv
// Purpose : three-deep sample delay line plus a tap sequencer that drives a downstream 4:1 mux / MAC.
// Latency : select=01 is visible after the edge that accepts start; done is visible three edges later.
// Backpr. : no stall input; a start seen outside IDLE is dropped and recorded in the sticky overrun flag.
//
// Ports
//   clk        : system clock, all state updates on its rising edge
//   reset      : synchronous active-high reset, wins over every other input
//   start      : new-sample strobe, level-sampled, accepted only in IDLE
//   x_in       : 25-bit signed sample, captured into fk when start is accepted
//   clr_ovr    : clears the overrun flag (a rejected start on the same edge wins)
//   fk/fk_1/fk_2 : current / one-back / two-back samples, registered
//   select     : registered tap select (00 zero, 01 fk, 10 fk_1, 11 fk_2)
//   mac_first  : high on the first tap so the accumulator loads instead of adds
//   busy       : high for TAP0..FIN
//   done       : one-cycle pulse in FIN
//   overrun    : sticky, set by a rejected start
module fk_delay_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [24:0] x_in,
  input  logic        clr_ovr,
  output logic [24:0] fk,
  output logic [24:0] fk_1,
  output logic [24:0] fk_2,
  output logic [1:0]  select,
  output logic        mac_first,
  output logic        busy,
  output logic        done,
  output logic        overrun
);

  localparam int unsigned W = 25;

  // Tap select codes seen by the downstream sample mux.
  localparam logic [1:0] SEL_ZERO = 2'b00;
  localparam logic [1:0] SEL_FK   = 2'b01;
  localparam logic [1:0] SEL_FK1  = 2'b10;
  localparam logic [1:0] SEL_FK2  = 2'b11;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    TAP0 = 3'd1,
    TAP1 = 3'd2,
    TAP2 = 3'd3,
    FIN  = 3'd4
  } state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   fk_q, fk_1_q, fk_2_q;
  logic [W-1:0]   fk_d, fk_1_d, fk_2_d;
  logic [1:0]     select_q, select_d;
  logic           mac_first_q, mac_first_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           overrun_q, overrun_d;

  logic           in_idle;
  logic           accept;
  logic           reject;

  // Any encoding other than IDLE (including the three unused ones) counts
  // as "not idle", so a start during a corrupted state is also flagged.
  assign in_idle = (state_q == IDLE);
  assign accept  = start &  in_idle;
  assign reject  = start & ~in_idle;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic. The tap walk is unconditional once started;
  // unused encodings fall back to IDLE on the next edge.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE:    state_d = accept ? TAP0 : IDLE;
      TAP0:    state_d = TAP1;
      TAP1:    state_d = TAP2;
      TAP2:    state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: output decode. Decoded from the next state so that the registered
  // outputs line up with the state register in the same cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    select_d    = SEL_ZERO;
    mac_first_d = 1'b0;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    case (state_d)
      TAP0: begin
        select_d    = SEL_FK;
        mac_first_d = 1'b1;
        busy_d      = 1'b1;
      end
      TAP1: begin
        select_d = SEL_FK1;
        busy_d   = 1'b1;
      end
      TAP2: begin
        select_d = SEL_FK2;
        busy_d   = 1'b1;
      end
      FIN: begin
        select_d = SEL_ZERO;
        done_d   = 1'b1;
        busy_d   = 1'b1;
      end
      default: begin
        select_d = SEL_ZERO;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      select_q    <= SEL_ZERO;
      mac_first_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      select_q    <= select_d;
      mac_first_q <= mac_first_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Delay line: shifts only on an accepted start, plain bit copies so the
  // signed sample passes through untouched. Held for the whole tap walk.
  // ---------------------------------------------------------------------------
  always_comb begin
    fk_d   = fk_q;
    fk_1_d = fk_1_q;
    fk_2_d = fk_2_q;
    if (accept) begin
      fk_d   = x_in;
      fk_1_d = fk_q;
      fk_2_d = fk_1_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fk_q   <= '0;
      fk_1_q <= '0;
      fk_2_q <= '0;
    end else begin
      fk_q   <= fk_d;
      fk_1_q <= fk_1_d;
      fk_2_q <= fk_2_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Overrun: sticky; a rejected start beats a simultaneous clear so that no
  // dropped sample can go unreported.
  // ---------------------------------------------------------------------------
  always_comb begin
    overrun_d = overrun_q;
    if (reject) begin
      overrun_d = 1'b1;
    end else if (clr_ovr) begin
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= overrun_d;
    end
  end

  assign fk        = fk_q;
  assign fk_1      = fk_1_q;
  assign fk_2      = fk_2_q;
  assign select    = select_q;
  assign mac_first = mac_first_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_fk_delay_seq.sv
// Purpose : self-checking bench for fk_delay_seq; cycle model plus a done-time scoreboard.
// Latency : every DUT output is compared 1 ns after each rising edge.
// Backpr. : n/a (bench drives start freely, including during busy, to exercise overrun).
module tb_fk_delay_seq;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset   = 1'b1;
  logic        start   = 1'b0;
  logic        clr_ovr = 1'b0;
  logic [24:0] x_in    = '0;
  logic [24:0] fk, fk_1, fk_2;
  logic [1:0]  select;
  logic        mac_first, busy, done, overrun;

  fk_delay_seq dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .x_in      (x_in),
    .clr_ovr   (clr_ovr),
    .fk        (fk),
    .fk_1      (fk_1),
    .fk_2      (fk_2),
    .select    (select),
    .mac_first (mac_first),
    .busy      (busy),
    .done      (done),
    .overrun   (overrun)
  );

  typedef struct packed {
    logic [24:0] f0;
    logic [24:0] f1;
    logic [24:0] f2;
  } dl_t;

  dl_t         sb_q[$];
  int          n_chk  = 0;
  int          n_fail = 0;

  // Reference model: phase 0 = idle, 1..3 = taps, 4 = fin.
  int          m_ph  = 0;
  logic [24:0] m0    = '0;
  logic [24:0] m1    = '0;
  logic [24:0] m2    = '0;
  logic        m_ovr = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock: update the model with the inputs seen at the edge,
  // then compare every output and service the scoreboard on done.
  task automatic tick();
    logic rej;
    dl_t  e;
    @(posedge clk);
    if (reset) begin
      m_ph  = 0;
      m0    = '0;
      m1    = '0;
      m2    = '0;
      m_ovr = 1'b0;
      sb_q.delete();
    end else begin
      rej = start && (m_ph != 0);
      if (rej) m_ovr = 1'b1;
      else if (clr_ovr) m_ovr = 1'b0;
      if (m_ph == 0) begin
        if (start) begin
          m2   = m1;
          m1   = m0;
          m0   = x_in;
          m_ph = 1;
          sb_q.push_back({m0, m1, m2});
        end
      end else begin
        m_ph = (m_ph == 4) ? 0 : m_ph + 1;
      end
    end
    #1;
    chk("select",    {30'd0, select},    (m_ph == 4) ? 0 : m_ph);
    chk("mac_first", {31'd0, mac_first}, {31'd0, m_ph == 1});
    chk("busy",      {31'd0, busy},      {31'd0, m_ph != 0});
    chk("done",      {31'd0, done},      {31'd0, m_ph == 4});
    chk("fk",        {7'd0, fk},         {7'd0, m0});
    chk("fk_1",      {7'd0, fk_1},       {7'd0, m1});
    chk("fk_2",      {7'd0, fk_2},       {7'd0, m2});
    chk("overrun",   {31'd0, overrun},   {31'd0, m_ovr});
    if (done) begin
      chk("sb_pending_on_done", {31'd0, sb_q.size() > 0}, 32'd1);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("sb_fk",   {7'd0, fk},   {7'd0, e.f0});
        chk("sb_fk_1", {7'd0, fk_1}, {7'd0, e.f1});
        chk("sb_fk_2", {7'd0, fk_2}, {7'd0, e.f2});
      end
    end
  endtask

  task automatic run_one(input logic [24:0] v);
    x_in  = v;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
  endtask

  initial begin
    int lat;
    int acc;

    // Reset with start/clr_ovr also high: both must be discarded.
    reset   = 1'b1;
    start   = 1'b1;
    clr_ovr = 1'b1;
    x_in    = 25'h1FFFFFF;
    tick();
    tick();
    reset   = 1'b0;
    start   = 1'b0;
    clr_ovr = 1'b0;
    chk("rst_fk",      {7'd0, fk},        32'd0);
    chk("rst_select",  {30'd0, select},   32'd0);
    chk("rst_busy",    {31'd0, busy},     32'd0);
    chk("rst_overrun", {31'd0, overrun},  32'd0);
    tick();

    // Single sample and latency to done.
    x_in  = 25'h0000123;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("s1_select", {30'd0, select},    32'd1);
    chk("s1_macf",   {31'd0, mac_first}, 32'd1);
    chk("s1_fk",     {7'd0, fk},         32'h123);
    chk("s1_fk_1",   {7'd0, fk_1},       32'd0);
    lat = 1;
    while (!done && lat < 10) begin
      tick();
      lat++;
    end
    chk("s1_done_latency", lat, 4);
    tick();

    // Three samples in sequence.
    for (int v = 1; v <= 3; v++) run_one(25'(v));
    chk("abc_fk",   {7'd0, fk},   32'd3);
    chk("abc_fk_1", {7'd0, fk_1}, 32'd2);
    chk("abc_fk_2", {7'd0, fk_2}, 32'd1);

    // Rejected start in TAP1.
    x_in  = 25'h0000ABC;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    x_in  = 25'h1FFFFFF;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("ovr_fk_held", {7'd0, fk},      32'hABC);
    chk("ovr_set",     {31'd0, overrun}, 32'd1);
    repeat (5) tick();
    chk("ovr_sticky",  {31'd0, overrun}, 32'd1);
    clr_ovr = 1'b1;
    tick();
    clr_ovr = 1'b0;
    chk("ovr_cleared", {31'd0, overrun}, 32'd0);

    // Rejected start and clear on the same edge: set wins.
    x_in  = 25'h5;
    start = 1'b1;
    tick();
    clr_ovr = 1'b1;
    tick();
    start   = 1'b0;
    clr_ovr = 1'b0;
    chk("ovr_set_wins", {31'd0, overrun}, 32'd1);
    repeat (3) tick();
    clr_ovr = 1'b1;
    tick();
    clr_ovr = 1'b0;

    // Reset in TAP2.
    x_in  = 25'h77;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("mid_in_tap2", {30'd0, select}, 32'd3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_select", {30'd0, select}, 32'd0);
    chk("mid_busy",   {31'd0, busy},   32'd0);
    chk("mid_done",   {31'd0, done},   32'd0);
    chk("mid_fk",     {7'd0, fk},      32'd0);
    x_in  = 25'h99;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("mid_new_fk",   {7'd0, fk},   32'h99);
    chk("mid_new_fk_1", {7'd0, fk_1}, 32'd0);
    repeat (4) tick();

    // Start held high for 20 clocks.
    acc   = 0;
    start = 1'b1;
    for (int i = 0; i < 20; i++) begin
      x_in = 25'($urandom);
      tick();
      if (select == 2'b01 && mac_first) acc++;
    end
    start = 1'b0;
    chk("cont_accepts", acc, 4);
    chk("cont_overrun", {31'd0, overrun}, 32'd1);
    clr_ovr = 1'b1;
    tick();
    clr_ovr = 1'b0;

    // Boundary data, bit-exact.
    run_one(25'h1000000);
    run_one(25'h0FFFFFF);
    chk("bnd_fk_1", {7'd0, fk_1}, 32'h1000000);
    chk("bnd_fk",   {7'd0, fk},   32'h0FFFFFF);

    // Random traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      reset   = ($urandom_range(0, 49) == 0);
      start   = ($urandom_range(0, 2) == 0);
      clr_ovr = ($urandom_range(0, 7) == 0);
      x_in    = 25'($urandom);
      tick();
    end
    reset   = 1'b0;
    start   = 1'b0;
    clr_ovr = 1'b0;
    repeat (6) tick();
    chk("sb_left", sb_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
